// File: rtl/minimig_pkg.sv
// Shared types and default timing for the Minimig freeze/monitor path.
package minimig_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_ACK = 2'd2,
        HOLDOFF  = 2'd3
    } freeze_state_t;

    localparam int unsigned DEBOUNCE_LEN_DEF = 4096;
    localparam int unsigned PULSE_LEN_DEF    = 8;
    localparam int unsigned ACK_TIMEOUT_DEF  = 65535;
    localparam int unsigned HOLDOFF_LEN_DEF  = 32768;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/freeze_ctrl_debounce.sv
// Panel button conditioner: 2-flop synchroniser, stability counter and a
// one-tick press strobe on the debounced falling edge (button is active-low).
module debounce #(
    parameter int unsigned LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned DW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(LEN - 1);
    localparam logic [DW-1:0] CNT_ONE  = DW'(1);

    logic [1:0]    sync_q;
    logic [DW-1:0] cnt_q;
    logic          level_q;
    logic          prev_q;
    logic          sync;

    assign sync = sync_q[1];

    // Synchroniser runs on every clk so the async button is resolved promptly.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[0], btn_n};
    end

    // Accept a new level only after it has been stable for LEN enabled ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
        end else if (en) begin
            prev_q <= level_q;
            if (sync != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // prev_q lags level_q by one enabled tick, so this is high for exactly one tick.
    assign press = prev_q & ~level_q;

endmodule

// File: rtl/freeze_ctrl.sv
// Freeze request generator: merges button/OSD/keyboard sources and paces the
// freeze pulse against the cart's int7 handshake with a post-entry hold-off.
module freeze_ctrl
    import minimig_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LEN = DEBOUNCE_LEN_DEF,
    parameter int unsigned PULSE_LEN    = PULSE_LEN_DEF,
    parameter int unsigned ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
    parameter int unsigned HOLDOFF_LEN  = HOLDOFF_LEN_DEF
) (
    input  logic clk,
    input  logic cpu_rst,
    input  logic clk7_en,
    input  logic btn_freeze_n,
    input  logic osd_freeze,
    input  logic kbd_freeze,
    input  logic aron,
    input  logic int7,
    output logic freeze,
    output logic busy,
    output logic ack_timeout
);

    localparam int unsigned CNT_MAX = max3(PULSE_LEN, ACK_TIMEOUT + 1, HOLDOFF_LEN);
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_LEN - 1);
    localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    freeze_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic          freeze_q, freeze_d;
    logic          ack_q, ack_d;
    logic          kbd_prev_q;
    logic          btn_req;
    logic          kbd_req;
    logic          req;

    debounce #(
        .LEN (DEBOUNCE_LEN)
    ) u_btn (
        .clk   (clk),
        .rst   (cpu_rst),
        .en    (clk7_en),
        .btn_n (btn_freeze_n),
        .press (btn_req)
    );

    // Keyboard level history for rising-edge detection on enabled ticks.
    always_ff @(posedge clk) begin
        if (cpu_rst)      kbd_prev_q <= 1'b0;
        else if (clk7_en) kbd_prev_q <= kbd_freeze;
    end

    assign kbd_req = kbd_freeze & ~kbd_prev_q;
    assign req     = aron & (btn_req | kbd_req | osd_freeze);

    // State, shared counter and registered outputs.
    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            freeze_q <= 1'b0;
            ack_q    <= 1'b0;
        end else if (clk7_en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            freeze_q <= freeze_d;
            ack_q    <= ack_d;
        end
    end

    // Next-state logic; requests outside IDLE are simply not looked at.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        freeze_d = freeze_q;
        ack_d    = ack_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = PULSE;
                    cnt_d    = PULSE_LAST;
                    freeze_d = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d  = WAIT_ACK;
                    cnt_d    = '0;
                    freeze_d = 1'b0;
                    seen_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WAIT_ACK: begin
                seen_d = seen_q | int7;
                if (seen_q && !int7) begin
                    state_d = HOLDOFF;
                    cnt_d   = HOLD_LAST;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = HOLDOFF;
                    cnt_d   = HOLD_LAST;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign freeze      = freeze_q;
    assign ack_timeout = ack_q;
    assign busy        = (state_q != IDLE);

endmodule
